led_scan_driver: RTL and testbench

LED_SCAN_DRIVER -- requirements
Module: led_scan_driver

---
 rtl/led_scan_driver_pkg.sv | 36 +++
 rtl/led_scan_driver_tick_gen.sv | 30 +++
 rtl/led_scan_driver.sv | 76 +++++++
 tb/tb_led_scan_driver.sv | 126 ++++++++++++
 4 files changed

// File: rtl/led_scan_driver_pkg.sv
// Shared display constants and helpers for the four-digit LED scan driver.
package led_scan_driver_pkg;

  localparam int unsigned REFRESH_DIV_DEFAULT = 25000;
  localparam int unsigned DATA_W              = 16;
  localparam int unsigned NIB_W               = 4;
  localparam int unsigned IDX_W               = 2;

  // Active-low anode enables, one digit lit at a time.
  localparam logic [3:0] AN_DIGIT0 = 4'b1110;
  localparam logic [3:0] AN_DIGIT1 = 4'b1101;
  localparam logic [3:0] AN_DIGIT2 = 4'b1011;
  localparam logic [3:0] AN_DIGIT3 = 4'b0111;
  localparam logic [3:0] AN_OFF    = 4'b1111;

  // Anode pattern for a digit index.
  function automatic logic [3:0] anode_for(input logic [IDX_W-1:0] idx);
    logic [3:0] pat;
    pat = AN_OFF;
    case (idx)
      2'd0: pat = AN_DIGIT0;
      2'd1: pat = AN_DIGIT1;
      2'd2: pat = AN_DIGIT2;
      2'd3: pat = AN_DIGIT3;
      default: pat = AN_OFF;
    endcase
    return pat;
  endfunction

  // Nibble of a display word for a digit index; index 0 is the rightmost.
  function automatic logic [NIB_W-1:0] nibble_sel(input logic [DATA_W-1:0] value,
                                                  input logic [IDX_W-1:0]  idx);
    return value[{idx, 2'b00} +: NIB_W];
  endfunction

endpackage

// File: rtl/led_scan_driver_tick_gen.sv
// Refresh divider: counts 0..REFRESH_DIV-1 and flags the last count.
module scan_tick_gen
  import led_scan_driver_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = REFRESH_DIV_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [CNT_W-1:0] count;

  // Tick is decoded from the count so it lines up with the wrap cycle.
  assign tick = (count == CNT_W'(REFRESH_DIV - 1));

  // Free-running divider with wrap at the last count.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/led_scan_driver.sv
// Multiplexed four-digit LED scan driver with frame-synchronous value update.
module led_scan_driver
  import led_scan_driver_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = REFRESH_DIV_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] data_in,
  input  logic              blank,
  output logic [NIB_W-1:0]  digit_out,
  output logic [3:0]        an,
  output logic              ack
);

  logic              tick;
  logic [IDX_W-1:0]  index;
  logic              frame_end;
  logic [DATA_W-1:0] active;
  logic [DATA_W-1:0] pending;
  logic              pend_valid;

  scan_tick_gen #(
    .REFRESH_DIV (REFRESH_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  // Last tick of digit 3 closes the frame; display updates only here.
  assign frame_end = tick && (index == IDX_W'(3));

  // Digit index steps on every divider tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      index <= '0;
    end else if (tick) begin
      index <= index + IDX_W'(1);
    end
  end

  // Pending/active handoff: newest load wins, commit only at frame end.
  always_ff @(posedge clk) begin
    if (reset) begin
      active     <= '0;
      pending    <= '0;
      pend_valid <= 1'b0;
      ack        <= 1'b0;
    end else begin
      ack <= frame_end && pend_valid;
      if (frame_end && pend_valid) begin
        active <= pending;
      end
      if (load) begin
        pending    <= data_in;
        pend_valid <= 1'b1;
      end else if (frame_end) begin
        pend_valid <= 1'b0;
      end
    end
  end

  // Registered digit drive; blank only darkens the anodes.
  always_ff @(posedge clk) begin
    if (reset) begin
      an        <= AN_OFF;
      digit_out <= '0;
    end else begin
      an        <= blank ? AN_OFF : anode_for(index);
      digit_out <= nibble_sel(active, index);
    end
  end

endmodule

// File: tb/tb_led_scan_driver.sv
// Directed self-checking bench for led_scan_driver with REFRESH_DIV = 4.
module tb_led_scan_driver;

  logic        clk;
  logic        reset;
  logic        load;
  logic [15:0] data_in;
  logic        blank;
  logic [3:0]  digit_out;
  logic [3:0]  an;
  logic        ack;

  int checks;
  int failures;
  int n;  // rising edges since reset released

  logic [3:0] an_tbl [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  led_scan_driver #(
    .REFRESH_DIV (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .data_in   (data_in),
    .blank     (blank),
    .digit_out (digit_out),
    .an        (an),
    .ack       (ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s n=%0d got=%h exp=%h", tag, n, got, exp);
    end
  endtask

  // One clock with outputs compared against the expected displayed word.
  task automatic step(input logic [15:0] disp, input logic ack_exp, input logic blank_exp);
    int idx;
    logic [3:0] nib;
    @(posedge clk);
    n++;
    #1 load = 1'b0;
    @(negedge clk);
    idx = ((n - 1) / 4) % 4;
    nib = 4'(disp >> (4 * idx));
    check("an", 16'(an), blank_exp ? 16'h000F : 16'(an_tbl[idx]));
    check("digit_out", 16'(digit_out), 16'(nib));
    check("ack", 16'(ack), 16'(ack_exp));
  endtask

  // Clocks with reset held; outputs must sit at reset values.
  task automatic reset_cycles(input int count);
    for (int i = 0; i < count; i++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      check("rst_an", 16'(an), 16'h000F);
      check("rst_digit", 16'(digit_out), 16'h0000);
      check("rst_ack", 16'(ack), 16'h0000);
    end
  endtask

  initial begin
    clk      = 1'b0;
    reset    = 1'b1;
    load     = 1'b0;
    data_in  = 16'h0000;
    blank    = 1'b0;
    checks   = 0;
    failures = 0;
    n        = 0;

    // Reset held three cycles.
    reset_cycles(3);
    reset = 1'b0;
    n = 0;

    // Load 1234 mid-frame; commits at the edge-16 boundary.
    while (n < 4) step(16'h0000, 1'b0, 1'b0);
    load = 1'b1; data_in = 16'h1234;
    while (n < 48) step((n + 1 >= 17) ? 16'h1234 : 16'h0000, (n + 1 == 16), 1'b0);

    // AAAA then BEEF in one frame; only BEEF is shown, one ack.
    step(16'h1234, 1'b0, 1'b0);
    load = 1'b1; data_in = 16'hAAAA;
    while (n < 53) step(16'h1234, 1'b0, 1'b0);
    load = 1'b1; data_in = 16'hBEEF;
    while (n < 80) step((n + 1 >= 65) ? 16'hBEEF : 16'h1234, (n + 1 == 64), 1'b0);

    // 1111 pending, 2222 loaded on the boundary cycle.
    step(16'hBEEF, 1'b0, 1'b0);
    load = 1'b1; data_in = 16'h1111;
    while (n < 95) step(16'hBEEF, 1'b0, 1'b0);
    load = 1'b1; data_in = 16'h2222;
    while (n < 128)
      step((n + 1 <= 96) ? 16'hBEEF : ((n + 1 <= 112) ? 16'h1111 : 16'h2222),
           (n + 1 == 96) || (n + 1 == 112), 1'b0);

    // Blank for six cycles; scan keeps running underneath.
    while (n < 130) step(16'h2222, 1'b0, 1'b0);
    blank = 1'b1;
    while (n < 136) step(16'h2222, 1'b0, 1'b1);
    blank = 1'b0;
    while (n < 144) step(16'h2222, 1'b0, 1'b0);

    // Reset during index 2 with 5555 pending: discarded, no ack.
    step(16'h2222, 1'b0, 1'b0);
    load = 1'b1; data_in = 16'h5555;
    while (n < 153) step(16'h2222, 1'b0, 1'b0);
    reset = 1'b1;
    reset_cycles(3);
    reset = 1'b0;
    n = 0;
    while (n < 32) step(16'h0000, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
